// File: rtl/cla_pkg.sv
// Shared types and constants for the CLA frame accumulator.
// Build option: define CLA_ACC_SAT_EN to saturate the accumulator on overflow.
package cla_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;

  localparam logic [DATA_W-1:0] SAT_MAX = 8'h7F;
  localparam logic [DATA_W-1:0] SAT_MIN = 8'h80;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

  // Increment by one as a bit-level carry chain; keeps the count free of any adder operator.
  function automatic logic [CNT_W-1:0] cnt_incr(input logic [CNT_W-1:0] v);
    return v ^ {&v[6:0], &v[5:0], &v[4:0], &v[3:0], &v[2:0], &v[1:0], v[0], 1'b1};
  endfunction

endpackage

// File: rtl/cla_8bit_ovf_uvf.sv
// 8-bit two-group carry-lookahead adder with signed overflow/underflow flags.
module cla_8bit_ovf_uvf
  import cla_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum_c,
  output logic              ovf_c,
  output logic              uvf_c
);

  // Lookahead carries out of each bit of a 4-bit group (index 3 is the group carry-out).
  function automatic logic [3:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic ci);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & ci);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (&p & ci);
    return c;
  endfunction

  logic [DATA_W-1:0] gen;
  logic [DATA_W-1:0] prop;
  logic [3:0]        c_lo;
  logic [3:0]        c_hi;
  logic [DATA_W-1:0] c_in;

  // Generate/propagate, group carries and sum bits.
  always_comb begin
    gen   = a & b;
    prop  = a ^ b;
    c_lo  = cla4(gen[3:0], prop[3:0], 1'b0);
    c_hi  = cla4(gen[7:4], prop[7:4], c_lo[3]);
    c_in  = {c_hi[2:0], c_lo[3:0], 1'b0};
    sum_c = prop ^ c_in;
    // Sign-bit carry-in vs carry-out disagree only when both operands share a sign.
    ovf_c = c_in[7] & ~c_hi[3];
    uvf_c = ~c_in[7] & c_hi[3];
  end

endmodule

// File: rtl/cla_acc_8bit.sv
// Frame accumulator: sums BLOCK_LEN signed bytes per frame, then holds the result
// with sticky overflow/underflow flags until downstream accepts it.
// Build option: CLA_ACC_SAT_EN clamps the accumulator to 0x7F/0x80 on overflow.
module cla_acc_8bit
  import cla_pkg::*;
#(
  parameter int unsigned BLOCK_LEN = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_ovf,
  output logic              out_uvf,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN);

  acc_state_t        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              uvf_q, uvf_d;

  logic [DATA_W-1:0] add_sum;
  logic              add_ovf;
  logic              add_uvf;
  logic [DATA_W-1:0] step_acc;
  logic [CNT_W-1:0]  cnt_inc;
  logic              in_hs;

  // acc is always zero in IDLE, so the same adder path starts a frame with 0 + in_data.
  cla_8bit_ovf_uvf u_add (
    .a     (acc_q),
    .b     (in_data),
    .sum_c (add_sum),
    .ovf_c (add_ovf),
    .uvf_c (add_uvf)
  );

  // Status outputs decoded straight from the state and data flops.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  assign out_uvf   = uvf_q;
  assign in_hs     = in_valid & in_ready;
  assign cnt_inc   = cnt_incr(cnt_q);

  // Value loaded into acc on an accepted operand.
  always_comb begin
    step_acc = add_sum;
`ifdef CLA_ACC_SAT_EN
    if (add_ovf) begin
      step_acc = SAT_MAX;
    end else if (add_uvf) begin
      step_acc = SAT_MIN;
    end
`endif
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    uvf_d   = uvf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      uvf_d   = 1'b0;
    end else begin
      unique case (state_q)
        // cnt is zero in IDLE and BLOCK_LEN >= 2, so the first operand always lands in ACCUM.
        IDLE, ACCUM: begin
          if (in_hs) begin
            acc_d   = step_acc;
            cnt_d   = cnt_inc;
            ovf_d   = ovf_q | add_ovf;
            uvf_d   = uvf_q | add_uvf;
            state_d = (cnt_inc == LAST_CNT) ? HOLD : ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            uvf_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          uvf_d   = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      uvf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      uvf_q   <= uvf_d;
    end
  end

endmodule

// File: tb/tb_cla_acc_8bit.sv
// Self-checking bench for cla_acc_8bit (BLOCK_LEN = 4).
module tb_cla_acc_8bit;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_ovf;
  logic       out_uvf;
  logic       busy;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [3:0][7:0] ops;
    logic [7:0]      exp_d;
    logic            exp_o;
    logic            exp_u;
    string           name;
  } vec_t;

  vec_t vecs[4];

  cla_acc_8bit #(.BLOCK_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_uvf   (out_uvf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  function automatic logic [3:0][7:0] mk(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c, input logic [7:0] d);
    logic [3:0][7:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  // Reference: signed integer running sum, clamped or wrapped after every operand.
  task automatic model(input logic [3:0][7:0] ops, output logic [7:0] d,
                       output logic o, output logic u);
    int a;
    int s;
    a = 0; o = 1'b0; u = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = a + int'($signed(ops[i]));
      if (s > 127)  o = 1'b1;
      if (s < -128) u = 1'b1;
`ifdef CLA_ACC_SAT_EN
      a = (s > 127) ? 127 : ((s < -128) ? -128 : s);
`else
      a = int'($signed(8'(s)));
`endif
    end
    d = 8'(a);
  endtask

  // Feed four operands with optional idle gaps; leaves in_valid high afterwards.
  task automatic send_ops(input logic [3:0][7:0] ops, input int gapmax, input string nm);
    for (int i = 0; i < 4; i++) begin
      int g;
      g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      for (int k = 0; k < g; k++) begin
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = ops[i];
      chk({nm, ".in_ready"}, 32'(in_ready), 32'd1);
      @(posedge clk); @(negedge clk);
    end
    in_data = 8'h55;
  endtask

  // Result must be presented now; stall, then accept and confirm the clean return to IDLE.
  task automatic drain(input int hold, input logic [7:0] ed, input logic eo, input logic eu,
                       input string nm);
    chk({nm, ".out_valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".out_data"}, 32'(out_data), 32'(ed));
    chk({nm, ".out_ovf"}, 32'(out_ovf), 32'(eo));
    chk({nm, ".out_uvf"}, 32'(out_uvf), 32'(eu));
    chk({nm, ".hold_ready"}, 32'(in_ready), 32'd0);
    for (int k = 0; k < hold; k++) begin
      out_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      chk({nm, ".stall_valid"}, 32'(out_valid), 32'd1);
      chk({nm, ".stall_data"}, 32'(out_data), 32'(ed));
      chk({nm, ".stall_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk({nm, ".post_valid"}, 32'(out_valid), 32'd0);
    chk({nm, ".post_data"}, 32'(out_data), 32'd0);
    chk({nm, ".post_busy"}, 32'(busy), 32'd0);
    chk({nm, ".post_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [3:0][7:0] ops;
    logic [7:0]      ed;
    logic            eo, eu;

    rst_n = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

    vecs[0] = '{mk(8'd10, 8'd20, 8'd30, 8'd40), 8'h64, 1'b0, 1'b0, "basic"};
`ifdef CLA_ACC_SAT_EN
    vecs[1] = '{mk(8'd100, 8'd50, 8'd0, 8'd0), 8'h7F, 1'b1, 1'b0, "ovf"};
    vecs[2] = '{mk(8'h9C, 8'hCE, 8'd0, 8'd0), 8'h80, 1'b0, 1'b1, "uvf"};
    vecs[3] = '{mk(8'd127, 8'd1, 8'hFF, 8'd0), 8'h7E, 1'b1, 1'b0, "edge"};
`else
    vecs[1] = '{mk(8'd100, 8'd50, 8'd0, 8'd0), 8'h96, 1'b1, 1'b0, "ovf"};
    vecs[2] = '{mk(8'h9C, 8'hCE, 8'd0, 8'd0), 8'h6A, 1'b0, 1'b1, "uvf"};
    vecs[3] = '{mk(8'd127, 8'd1, 8'hFF, 8'd0), 8'h7F, 1'b1, 1'b1, "edge"};
`endif

    // Reset values, asynchronously, before any clock edge.
    #5 rst_n = 1'b0;
    #1;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.flags", 32'({out_ovf, out_uvf}), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors, back-to-back, with a 3-cycle stall on the first one.
    for (int v = 0; v < 4; v++) begin
      send_ops(vecs[v].ops, 0, vecs[v].name);
      drain((v == 0) ? 3 : 0, vecs[v].exp_d, vecs[v].exp_o, vecs[v].exp_u, vecs[v].name);
    end

    // Frame abort after two operands, then a fresh frame of ones.
    in_valid = 1'b1; in_data = 8'd9;
    @(posedge clk); @(negedge clk);
    in_data = 8'd7;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0;
    chk("clr.busy", 32'(busy), 32'd0);
    chk("clr.out_data", 32'(out_data), 32'd0);
    send_ops(mk(8'd1, 8'd1, 8'd1, 8'd1), 0, "clr_frame");
    drain(1, 8'd4, 1'b0, 1'b0, "clr_frame");

    // clear in HOLD drops out_valid even with out_ready high.
    send_ops(mk(8'd5, 8'd5, 8'd5, 8'd5), 0, "clr_hold");
    in_valid = 1'b0; out_ready = 1'b1; clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0; out_ready = 1'b0;
    chk("clr_hold.out_valid", 32'(out_valid), 32'd0);
    chk("clr_hold.out_data", 32'(out_data), 32'd0);

    // Reset pulse while holding a result: immediate reset values, no handshake afterwards.
    send_ops(mk(8'd100, 8'd100, 8'd1, 8'd1), 0, "rst_hold");
    in_valid = 1'b0;
    chk("rst_hold.pre_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_hold.out_valid", 32'(out_valid), 32'd0);
    chk("rst_hold.out_data", 32'(out_data), 32'd0);
    chk("rst_hold.flags", 32'({out_ovf, out_uvf}), 32'd0);
    chk("rst_hold.busy", 32'(busy), 32'd0);
    chk("rst_hold.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      chk("rst_hold.no_result", 32'(out_valid), 32'd0);
    end
    out_ready = 1'b0;

    // Random frames against the reference model.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 4; i++) ops[i] = 8'($urandom);
      model(ops, ed, eo, eu);
      send_ops(ops, 2, $sformatf("rnd%0d", f));
      drain(int'($urandom_range(2, 0)), ed, eo, eu, $sformatf("rnd%0d", f));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute time bound so the bench always ends.
  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
